// File: rtl/ps2_rx_frame_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive framer.
//   ps2_state_e    : framer FSM state encoding (IDLE/SHIFT/DONE)
//   PS2_FRAME_BITS : bits per device frame (start + 8 data + parity + stop)
//   PS2_DATA_BITS  : payload bits per frame
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if: bundle of the framer's line inputs and receive results.
//   ps2c, ps2d    : raw PS/2 clock/data lines (asynchronous)
//   rx_en         : receive enable, gates frame start only
//   rx_idle       : framer is in IDLE
//   rx_done_tick  : one-cycle strobe, dout valid in same cycle
//   dout          : last good byte, held between strobes
//   frame_err     : one-cycle error/timeout strobe
// master = framer side, slave = line driver / consumer side.
interface ps2_rx_frame_if;
  import ps2_pkg::*;

  logic                     ps2c;
  logic                     ps2d;
  logic                     rx_en;
  logic                     rx_idle;
  logic                     rx_done_tick;
  logic [PS2_DATA_BITS-1:0] dout;
  logic                     frame_err;

  modport master (
    input  ps2c, ps2d, rx_en,
    output rx_idle, rx_done_tick, dout, frame_err
  );

  modport slave (
    output ps2c, ps2d, rx_en,
    input  rx_idle, rx_done_tick, dout, frame_err
  );

endinterface

// File: rtl/ps2_rx_frame_edge_filter.sv
// ps2_edge_filter: two-flop synchronizers on ps2c/ps2d, debounce filter on
// the synchronized clock, and a single-cycle pulse on its falling edge.
//   clk, reset : system clock, async active-high reset
//   ps2c, ps2d : raw PS/2 lines
//   fall_edge  : one-cycle pulse when the filtered clock level drops 1 -> 0
//   ps2d_sync  : synchronized data line
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_edge,
  output logic ps2d_sync
);

  logic [1:0]            c_sync_q;
  logic [1:0]            d_sync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  lvl_q;
  logic                  lvl_d;

  // Level changes only when the whole window agrees; mixed windows hold.
  always_comb begin
    lvl_d = lvl_q;
    if (&filt_q)
      lvl_d = 1'b1;
    else if (~|filt_q)
      lvl_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q   <= '1;
      lvl_q    <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      filt_q   <= {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
      lvl_q    <= lvl_d;
    end
  end

  // lvl_d is the current filtered level; lvl_q is last cycle's.
  assign fall_edge = lvl_q & ~lvl_d;
  assign ps2d_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 receive framer. Shifts in 11-bit frames on filtered
// ps2c falling edges and emits one byte per frame with a one-cycle strobe
// that feeds the receive FIFO write enable. An inactivity watchdog aborts
// partial frames.
//   clk, reset : system clock, async active-high reset
//   bus        : ps2_rx_frame_if.master (ps2c, ps2d, rx_en in;
//                rx_idle, rx_done_tick, dout, frame_err out)
// Build option: PS2_RX_CHK_EN enables start/stop/parity checking and the
// frame_err strobe; without it every completed frame is accepted and
// frame_err stays 0.
//
// state | meaning
// IDLE  | waiting for a start edge while rx_en is high
// SHIFT | sampling bits on each falling edge, watchdog running
// DONE  | one cycle, strobes reflect the evaluated frame
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_W  = 18
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_frame_if.master bus
);

  logic                      fall_edge;
  logic                      ps2d_sync;

  ps2_state_e                state_q;
  logic [PS2_FRAME_BITS-1:0] sr_q;
  logic [PS2_FRAME_BITS-1:0] sr_d;
  logic [3:0]                cnt_q;
  logic [TIMEOUT_W-1:0]      tmr_q;
  logic                      rx_idle_q;
  logic                      rx_done_tick_q;
  logic                      frame_err_q;
  logic [PS2_DATA_BITS-1:0]  dout_q;
  logic                      frame_ok;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (bus.ps2c),
    .ps2d      (bus.ps2d),
    .fall_edge (fall_edge),
    .ps2d_sync (ps2d_sync)
  );

  // Right shift with the new sample entering at the MSB; after 11 edges
  // bit 0 holds the start bit and bit 10 the stop bit.
  assign sr_d = {ps2d_sync, sr_q[PS2_FRAME_BITS-1:1]};

  // The frame is judged on the shifted value so the strobe lands in DONE.
`ifdef PS2_RX_CHK_EN
  assign frame_ok = ~sr_d[0] & sr_d[PS2_FRAME_BITS-1] &
                    odd_parity_ok(sr_d[PS2_DATA_BITS+1:1]);
`else
  logic unused_start_bit;
  assign unused_start_bit = sr_q[0];
  assign frame_ok         = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      cnt_q          <= '0;
      tmr_q          <= '0;
      rx_idle_q      <= 1'b1;
      rx_done_tick_q <= 1'b0;
      frame_err_q    <= 1'b0;
      dout_q         <= '0;
    end else begin
      rx_done_tick_q <= 1'b0;
      frame_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_edge && bus.rx_en) begin
            sr_q      <= sr_d;
            cnt_q     <= 4'd9;
            tmr_q     <= '0;
            rx_idle_q <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall_edge) begin
            sr_q  <= sr_d;
            tmr_q <= '0;
            if (cnt_q == 4'd0) begin
              state_q <= DONE;
              if (frame_ok) begin
                rx_done_tick_q <= 1'b1;
                dout_q         <= sr_d[PS2_DATA_BITS:1];
              end else begin
`ifdef PS2_RX_CHK_EN
                frame_err_q <= 1'b1;
`endif
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end else if (&tmr_q) begin
            // Line went quiet mid-frame: drop the partial frame.
            tmr_q     <= '0;
            rx_idle_q <= 1'b1;
            state_q   <= IDLE;
`ifdef PS2_RX_CHK_EN
            frame_err_q <= 1'b1;
`endif
          end else begin
            tmr_q <= tmr_q + TIMEOUT_W'(1);
          end
        end
        DONE: begin
          rx_idle_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          rx_idle_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_idle      = rx_idle_q;
  assign bus.rx_done_tick = rx_done_tick_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.dout         = dout_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed frames into ps2_rx_frame with a scoreboard of
// expected strobes; a monitor pops and compares on every rx_done_tick or
// frame_err. Uses a short watchdog (TIMEOUT_W = 10) so the abort case fits.
module tb_ps2_rx_frame;

  localparam int HALF   = 25;
  localparam int FLEN   = 8;
  localparam int TOW    = 10;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   idle_low_cnt;
  logic idle_watch;
  exp_t exp_q[$];

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN (FLEN),
    .TIMEOUT_W  (TOW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip_par);
    logic par;
    par = ~(^d) ^ flip_par;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Drives nbits bits LSB first; glitch[i] injects a FLEN-1 cycle low pulse
  // in the high phase before bit i's falling edge.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input logic [10:0] glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = bits[i];
      if (glitch[i]) begin
        repeat (8) @(negedge clk);
        bus.ps2c = 1'b0;
        repeat (FLEN - 1) @(negedge clk);
        bus.ps2c = 1'b1;
        repeat (HALF - 8 - (FLEN - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.ps2c = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2c = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    bus.ps2d = 1'b1;
  endtask

  task automatic push_tick(input logic [7:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
  endtask

  task automatic push_err();
    exp_q.push_back('{is_err: 1'b1, data: 8'h00});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_idle"}, 32'(bus.rx_idle), 32'd1);
    check({tag, "_tick"},    32'(bus.rx_done_tick), 32'd0);
    check({tag, "_err"},     32'(bus.frame_err), 32'd0);
    check({tag, "_dout"},    32'(bus.dout), 32'h00);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_done_tick || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe tick=%0b err=%0b dout=%0h expected=none",
                   bus.rx_done_tick, bus.frame_err, bus.dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_err",  32'(bus.frame_err), 32'(e.is_err));
          check("strobe_tick", 32'(bus.rx_done_tick), 32'(!e.is_err));
          if (!e.is_err)
            check("strobe_dout", 32'(bus.dout), 32'(e.data));
        end
      end
      if (idle_watch && !bus.rx_idle)
        idle_low_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    idle_low_cnt = 0;
    idle_watch   = 1'b0;
    reset        = 1'b1;
    bus.ps2c     = 1'b1;
    bus.ps2d     = 1'b1;
    bus.rx_en    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame 0x1C (parity 0)
    push_tick(8'h1C);
    send_bits(mk_frame(8'h1C, 1'b0), 11, 11'h000);
    check("dout_after_1c", 32'(bus.dout), 32'h1C);

    // Parity flipped: rejected only when checking is built in
`ifdef PS2_RX_CHK_EN
    push_err();
`else
    push_tick(8'h1C);
`endif
    send_bits(mk_frame(8'h1C, 1'b1), 11, 11'h000);
    check("dout_after_badpar", 32'(bus.dout), 32'h1C);

    // Sub-threshold glitches before bits 3 and 7 must not add bits
    push_tick(8'hF0);
    send_bits(mk_frame(8'hF0, 1'b0), 11, 11'h088);
    check("dout_after_glitch", 32'(bus.dout), 32'hF0);

    // Stall after 5 bits long enough for the watchdog to fire
`ifdef PS2_RX_CHK_EN
    push_err();
`endif
    send_bits(mk_frame(8'hAA, 1'b0), 5, 11'h000);
    check("idle_before_timeout", 32'(bus.rx_idle), 32'd0);
    repeat (1100) @(negedge clk);
    check("idle_after_timeout", 32'(bus.rx_idle), 32'd1);
    push_tick(8'hAA);
    send_bits(mk_frame(8'hAA, 1'b0), 11, 11'h000);
    check("dout_after_aa", 32'(bus.dout), 32'hAA);

    // Receiver disabled: a whole frame is ignored
    bus.rx_en  = 1'b0;
    idle_watch = 1'b1;
    send_bits(mk_frame(8'h33, 1'b0), 11, 11'h000);
    idle_watch = 1'b0;
    check("idle_low_while_disabled", 32'(idle_low_cnt), 32'd0);
    check("dout_while_disabled", 32'(bus.dout), 32'hAA);
    bus.rx_en = 1'b1;
    push_tick(8'h55);
    send_bits(mk_frame(8'h55, 1'b0), 11, 11'h000);
    check("dout_after_55", 32'(bus.dout), 32'h55);

    // Reset after the 6th bit discards the partial frame
    send_bits(mk_frame(8'h77, 1'b0), 6, 11'h000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    push_tick(8'h12);
    send_bits(mk_frame(8'h12, 1'b0), 11, 11'h000);
    check("dout_after_12", 32'(bus.dout), 32'h12);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
